// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package inst_fetch_pkg;

    localparam int unsigned REGWIDTH = 32;
    localparam logic [REGWIDTH-1:0] PC_RESET_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    // In-flight and drop counters; must cover the worst-case number of
    // unreturned requests across back-to-back redirects.
    localparam int unsigned CNTW = 8;

    typedef enum logic [1:0] {
        IF_BOOT = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_e;

    function automatic logic [REGWIDTH-1:0] align_word(input logic [REGWIDTH-1:0] a);
        return {a[REGWIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, inst} records with flush.
module inst_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Head reads as zero when empty so the outputs carry no stale data.
    assign o_head    = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr] <= i_push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, request credit, stale-response dropping, and the
// decode-facing instruction buffer.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [REGWIDTH-1:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned         DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [REGWIDTH-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [REGWIDTH-1:0] imem_rsp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [REGWIDTH-1:0] inst,
    output logic [REGWIDTH-1:0] inst_pc,
    input  logic                redirect_valid,
    input  logic [REGWIDTH-1:0] redirect_pc,
    input  logic                halt,
    output logic                misalign_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    if_state_e           r_state;
    if_state_e           w_state_next;
    logic [REGWIDTH-1:0] r_pc;
    logic [REGWIDTH-1:0] r_rsp_pc;
    logic [CNTW-1:0]     r_out;
    logic [CNTW-1:0]     r_drop;
    logic                r_hold;

    logic                w_req_fire;
    logic                w_rsp_keep;
    logic                w_rsp_drop;
    logic                w_pop;
    logic [CNTW-1:0]     w_live;
    logic [CNTW:0]       w_occ;
    logic                w_credit;
    logic [CW-1:0]       w_count;
    logic                w_empty;
    logic                w_full;
    logic [2*REGWIDTH-1:0] w_head;

    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_rsp_keep = imem_rsp_valid & ~redirect_valid & (r_drop == '0);
    assign w_rsp_drop = imem_rsp_valid & ~redirect_valid & (r_drop != '0);
    assign w_pop      = inst_valid & inst_ready;

    // Requests destined to be dropped never occupy the buffer, and a slot
    // freed by this cycle's pop is usable by a request issued now.
    assign w_live   = r_out - r_drop;
    assign w_occ    = {1'b0, w_live} + (CNTW+1)'(w_count) - (CNTW+1)'(w_pop);
    assign w_credit = (w_occ < (CNTW+1)'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IF_BOOT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IF_BOOT: w_state_next = IF_RUN;
            IF_RUN:  if (halt)  w_state_next = IF_HALT;
            IF_HALT: if (!halt) w_state_next = IF_RUN;
            default: w_state_next = IF_BOOT;
        endcase
    end

    // A request left pending by a low ready is held until accepted, so
    // valid/address stay stable even if halt or credit change meanwhile.
    always_comb begin
        imem_req_valid = 1'b0;
        if (!redirect_valid)
            imem_req_valid = r_hold | ((r_state == IF_RUN) & w_credit);
    end

    assign imem_addr    = r_pc;
    assign misalign_err = redirect_valid & (|redirect_pc[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= PC_RESET;
            r_rsp_pc <= PC_RESET;
            r_out    <= '0;
            r_drop   <= '0;
            r_hold   <= 1'b0;
        end else begin
            r_hold <= imem_req_valid & ~imem_req_ready;
            r_out  <= r_out + CNTW'(w_req_fire) - CNTW'(imem_rsp_valid);
            if (redirect_valid) begin
                r_pc     <= align_word(redirect_pc);
                r_rsp_pc <= align_word(redirect_pc);
                r_drop   <= r_out - CNTW'(imem_rsp_valid);
            end else begin
                if (w_req_fire) r_pc     <= r_pc + 32'd4;
                if (w_rsp_keep) r_rsp_pc <= r_rsp_pc + 32'd4;
                if (w_rsp_drop) r_drop   <= r_drop - CNTW'(1);
            end
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*REGWIDTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (w_rsp_keep),
        .i_push_data ({r_rsp_pc, imem_rsp_data}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    assign inst_valid = ~w_empty;
    assign inst_pc    = w_head[2*REGWIDTH-1:REGWIDTH];
    assign inst       = w_head[REGWIDTH-1:0];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_rsp_keep && w_full && !w_pop));

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: cycle table, directed corner cases,
// and a randomized run against a stream-level reference model.
module tb_inst_fetch;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        misalign_err;

    inst_fetch #(
        .PC_RESET (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // In-order memory model: each accepted request returns after a latency.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    mreq_t       mq[$];
    int unsigned cyc;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic        mem_rand_ready = 1'b0;

    task automatic cyc_begin();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        imem_req_ready = mem_rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
        #1;
    endtask

    task automatic cyc_end();
        if (imem_rsp_valid) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready)
            mq.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_min, lat_max)});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk ({tag, "_addr"},      imem_addr,      32'h0);
        chk1({tag, "_inst_valid"}, inst_valid,    1'b0);
        chk ({tag, "_inst"},      inst,           32'h0);
        chk ({tag, "_inst_pc"},   inst_pc,        32'h0);
        chk1({tag, "_misalign"},  misalign_err,   1'b0);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        inst_ready     = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b1;
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_hs(output logic [31:0] pc, output logic [31:0] data, output logic ok);
        ok   = 1'b0;
        pc   = '0;
        data = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cyc_begin();
            if (inst_valid && inst_ready) begin
                ok   = 1'b1;
                pc   = inst_pc;
                data = inst;
            end
            cyc_end();
        end
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        chk_addr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[11];
        logic [31:0] pc_a, pc_b, d_a, d_b;
        logic        ok_a, ok_b;
        int unsigned fires;
        logic        got_hs;
        logic [31:0] hs_pc;

        tbl[0]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h000, 1'b0, 32'h000, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h004, 1'b0, 32'h000, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h008, 1'b1, 32'h000, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h00C, 1'b1, 32'h004, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h008, 1'b0};
        tbl[6]  = '{1'b1, 32'h202, 1'b0, 1'b0, 32'h000, 1'b1, 32'h00C, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h000, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h200, 1'b0};
        tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h20C, 1'b1, 32'h204, 1'b0};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        inst_ready     = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b1;
        #3;
        check_reset_outputs("por");

        // Startup, steady streaming and a misaligned redirect, cycle by cycle.
        lat_min = 1; lat_max = 1; mem_rand_ready = 1'b0;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            cyc_begin();
            chk1($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].e_req);
            if (tbl[i].chk_addr) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk1($sformatf("tbl%0d_inst_valid", i), inst_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), inst, memword(tbl[i].e_pc));
            end
            chk1($sformatf("tbl%0d_misalign", i), misalign_err, tbl[i].e_mis);
            cyc_end();
        end
        redirect_valid = 1'b0;

        // Decode stalled: credit caps requests at DEPTH, head word holds.
        do_reset();
        inst_ready = 1'b0;
        fires = 0;
        repeat (10) begin
            cyc_begin();
            if (imem_req_valid && imem_req_ready) fires++;
            cyc_end();
        end
        cyc_begin();
        chk("stall_req_count", fires, DEPTH);
        chk1("stall_req_valid", imem_req_valid, 1'b0);
        chk1("stall_inst_valid", inst_valid, 1'b1);
        chk("stall_inst_pc", inst_pc, 32'h0);
        chk("stall_inst", inst, memword(32'h0));
        cyc_end();
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc_begin();
            chk1($sformatf("resume%0d_valid", k), inst_valid, 1'b1);
            chk($sformatf("resume%0d_pc", k), inst_pc, 32'(4 * k));
            cyc_end();
        end

        // Redirect with two requests outstanding on a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        do_reset();
        inst_ready = 1'b1;
        fires = 0;
        repeat (3) begin
            cyc_begin();
            if (imem_req_valid && imem_req_ready) fires++;
            cyc_end();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc_begin();
        chk("redir_outstanding", fires, 2);
        chk1("redir_req_forced_low", imem_req_valid, 1'b0);
        cyc_end();
        redirect_valid = 1'b0;
        wait_hs(pc_a, d_a, ok_a);
        wait_hs(pc_b, d_b, ok_b);
        chk1("redir_hs0_seen", ok_a, 1'b1);
        chk("redir_hs0_pc", pc_a, 32'h100);
        chk("redir_hs0_inst", d_a, memword(32'h100));
        chk1("redir_hs1_seen", ok_b, 1'b1);
        chk("redir_hs1_pc", pc_b, 32'h104);

        // Redirect coinciding with a decode handshake and a response.
        lat_min = 1; lat_max = 1;
        do_reset();
        inst_ready = 1'b1;
        repeat (4) begin
            cyc_begin();
            cyc_end();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        cyc_begin();
        chk1("coinc_inst_valid", inst_valid, 1'b1);
        chk("coinc_inst_pc", inst_pc, 32'h4);
        cyc_end();
        redirect_valid = 1'b0;
        wait_hs(pc_a, d_a, ok_a);
        chk1("coinc_next_seen", ok_a, 1'b1);
        chk("coinc_next_pc", pc_a, 32'h300);
        chk("coinc_next_inst", d_a, memword(32'h300));

        // Halt with one request outstanding, then resume.
        lat_min = 3; lat_max = 3;
        do_reset();
        inst_ready = 1'b1;
        cyc_begin();
        cyc_end();
        halt = 1'b1;
        cyc_begin();
        chk1("halt_first_req", imem_req_valid, 1'b1);
        chk("halt_first_addr", imem_addr, 32'h0);
        cyc_end();
        fires  = 0;
        got_hs = 1'b0;
        hs_pc  = '1;
        repeat (8) begin
            cyc_begin();
            if (imem_req_valid && imem_req_ready) fires++;
            if (inst_valid && inst_ready && !got_hs) begin
                got_hs = 1'b1;
                hs_pc  = inst_pc;
            end
            cyc_end();
        end
        chk("halt_no_requests", fires, 0);
        chk1("halt_word_delivered", got_hs, 1'b1);
        chk("halt_word_pc", hs_pc, 32'h0);
        halt  = 1'b0;
        ok_a  = 1'b0;
        pc_a  = '1;
        for (int i = 0; i < 10 && !ok_a; i++) begin
            cyc_begin();
            if (imem_req_valid && imem_req_ready) begin
                ok_a = 1'b1;
                pc_a = imem_addr;
            end
            cyc_end();
        end
        chk1("unhalt_req_seen", ok_a, 1'b1);
        chk("unhalt_req_addr", pc_a, 32'h4);
        wait_hs(pc_b, d_b, ok_b);
        chk1("unhalt_hs_seen", ok_b, 1'b1);
        chk("unhalt_hs_pc", pc_b, 32'h4);

        // Asynchronous reset mid-stream clears outputs immediately.
        lat_min = 1; lat_max = 1;
        repeat (4) begin
            cyc_begin();
            cyc_end();
        end
        cyc_begin();
        chk1("prerst_inst_valid", inst_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        mq.delete();
        imem_rsp_valid = 1'b0;

        // Randomized run against a stream-level model.
        begin
            logic [31:0] fetch_pc, exp_pc, prev_addr;
            logic        prev_pending;
            int unsigned n_hs;
            lat_min = 1; lat_max = 4; mem_rand_ready = 1'b1;
            do_reset();
            fetch_pc     = 32'h0;
            exp_pc       = 32'h0;
            prev_pending = 1'b0;
            prev_addr    = '0;
            n_hs         = 0;
            for (int i = 0; i < 2000; i++) begin
                inst_ready     = ($urandom_range(0, 9) < 7);
                redirect_valid = ($urandom_range(0, 99) < 4);
                redirect_pc    = $urandom() & 32'h0000_0FFF;
                if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | (redirect_pc & 32'h3);
                if ($urandom_range(0, 1) == 0) redirect_pc = redirect_pc & ~32'h3;
                if ($urandom_range(0, 99) < 3) halt = ~halt;
                cyc_begin();
                if (misalign_err !== (redirect_valid & (|redirect_pc[1:0])))
                    chk1("rnd_misalign", misalign_err, redirect_valid & (|redirect_pc[1:0]));
                else n_tests++;
                if (redirect_valid) chk1("rnd_redir_req_low", imem_req_valid, 1'b0);
                if (prev_pending && !redirect_valid) begin
                    chk1("rnd_hold_valid", imem_req_valid, 1'b1);
                    chk("rnd_hold_addr", imem_addr, prev_addr);
                end
                if (imem_req_valid && imem_req_ready) begin
                    chk("rnd_fetch_addr", imem_addr, fetch_pc);
                    fetch_pc = fetch_pc + 32'd4;
                end
                if (inst_valid && inst_ready) begin
                    chk("rnd_inst_pc", inst_pc, exp_pc);
                    chk("rnd_inst", inst, memword(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    n_hs++;
                end
                if (redirect_valid) begin
                    fetch_pc = {redirect_pc[31:2], 2'b00};
                    exp_pc   = {redirect_pc[31:2], 2'b00};
                end
                prev_pending = imem_req_valid & ~imem_req_ready;
                prev_addr    = imem_addr;
                cyc_end();
            end
            chk1("rnd_progress", n_hs > 200, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: owns the program counter, issues word requests to instruction memory, buffers returned words, and presents one instruction per handshake to the decode stage (the `Controller`). Branch, JAL and JALR resolution redirects it through a single redirect port. It is the producer of the `inst` word that decode consumes and sits between the instruction memory and decode.

## Interface
- `PC_RESET`, 32'h0000_0000, PC value loaded at reset.
- `DEPTH`, 2, instruction buffer entries; this is also the cap on in-flight plus buffered words. Power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  `REGWIDTH`  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response word present; responses arrive in order, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  `REGWIDTH`  instruction word.
- `inst_valid`  out  1  `inst`/`inst_pc` valid to decode.
- `inst_ready`  in  1  decode accepts.
- `inst`  out  `REGWIDTH`  instruction word.
- `inst_pc`  out  `REGWIDTH`  address of `inst`.
- `redirect_valid`  in  1  one-cycle control-flow change.
- `redirect_pc`  in  `REGWIDTH`  new fetch target.
- `halt`  in  1  level; stops issuing new requests.
- `misalign_err`  out  1  one-cycle pulse when `redirect_pc[1:0]` is nonzero.

## Operation
- FSM states: BOOT, RUN, HALTED.
  - BOOT: entered on reset. One cycle with no request, then RUN.
  - RUN → HALTED when `halt`=1.
  - HALTED → RUN when `halt`=0.
- HALTED: no new requests; in-flight responses are still accepted and buffered; decode handshakes continue.
- Request transfer: `imem_req_valid & imem_req_ready`. On transfer, `pc` advances by 4 (32-bit wrap, no flag).
- Request gating: `imem_req_valid`=1 only in RUN, with no redirect this cycle and `outstanding + count < DEPTH`.
- `imem_req_valid` and `imem_addr` stay stable while ready is low, unless a redirect occurs.
- Response: an accepted response word is pushed with its PC into the buffer, unless the drop counter is nonzero. In that case the word is discarded and the drop counter decrements.
- PC tracking: a second PC register (`rsp_pc`) tags responses and advances by 4 per kept response.
- Output: `inst_valid` = buffer not empty; `inst`/`inst_pc` come from the buffer head. Pop on `inst_valid & inst_ready`.
- Redirect, taking effect at the clock edge:
  - `pc` and `rsp_pc` ← `{redirect_pc[31:2],2'b00}`.
  - Buffer flushed.
  - Drop counter ← outstanding count, counting still-unreturned requests only.
  - `imem_req_valid` forced low in the redirect cycle.
  - A decode handshake in the same cycle completes: that instruction is consumed.
  - A response arriving in the redirect cycle is discarded and is not added to the drop count.
- Misaligned `redirect_pc`: low 2 bits cleared, `misalign_err` pulses in the same cycle. The team treats this as a fatal report only; it causes no other effect.
- Simultaneous push and pop with a full buffer is legal. The credit rule guarantees no overflow.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_addr`=`PC_RESET`.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0, `misalign_err`=0.
  - Counters zero, FSM=BOOT.
- First request at the 2nd rising edge after `rst` deasserts (after the BOOT cycle).
- Latency:
  - Response to `inst_valid`: 1 cycle (registered buffer).
  - Redirect to first new request: next cycle.
  - Redirect to first new `inst_valid`: memory latency + 2.
- Throughput: 1 instruction/cycle sustained when memory returns in 1 cycle and `DEPTH`≥2.
- Reset asserted mid-operation: all state cleared immediately. Responses arriving after reset release without a matching request are illegal stimulus.
- `inst` and `inst_pc` hold while `inst_valid & ~inst_ready`.

## Structure
- Shared `variables.v`: `REGWIDTH`, the opcode constants (`JAL`, `JALR`, `BRANCH`), `PC_RESET` default, and FSM state encodings `IF_BOOT`, `IF_RUN`, `IF_HALT`.
- Sub-module `inst_fifo`: synchronous FIFO, `DEPTH` entries × 64 bits ({pc, inst}), with push, pop, flush, count, empty and full.
- Top level holds the FSM, both PC registers, the outstanding counter and the drop counter.

## Test plan
- Reset release, memory ready always, 1-cycle latency, `inst_ready`=1: `imem_addr` sequence 0,4,8,…; `inst_pc` 0,4,8 on consecutive cycles starting 3 cycles after reset release.
- `inst_ready`=0 for 10 cycles: exactly `DEPTH` requests issued, then `imem_req_valid`=0. `inst` holds the word from 0x0; resume gives 0x0,0x4 with no gaps or duplicates.
- Redirect to 0x100 with 2 requests outstanding (3-cycle memory latency): both stale responses dropped; next `inst_pc`=0x100, then 0x104.
- Redirect to 0x202: `misalign_err`=1 for one cycle; fetch resumes at 0x200.
- Redirect in the same cycle as an `inst` handshake and an `imem_rsp_valid`: the handshaken instruction counts as consumed, the response is discarded, and the next `inst_pc` equals the target.
- `halt` raised with 1 request outstanding: no further requests; the outstanding word is still delivered. Dropping `halt` resumes at the next sequential PC. `rst` pulse mid-stream returns all outputs to reset values in the same cycle.
